// File: rtl/vdp_bus_bridge.sv
// CPU I/O to VDP bus bridge: stretches a CPU port access into a timed VDP
// read/write strobe, holding the CPU in wait until the strobe completes.
module vdp_bus_bridge #(
  parameter logic [7:0]  BASE_PORT     = 8'h30,
  parameter int unsigned STROBE_CYCLES = 8,
  parameter int unsigned GAP_CYCLES    = 4
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       iorq_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] addr,
  input  logic [7:0] cpu_d_i,
  output logic [7:0] cpu_d_o,
  output logic       cpu_d_oe,
  output logic       wait_n,
  output logic       vdp_csr_n,
  output logic       vdp_csw_n,
  output logic       vdp_mode,
  output logic [7:0] vdp_cd_o,
  input  logic [7:0] vdp_cd_i
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    GAP    = 3'd4
  } state_t;

  localparam logic [7:0] STROBE_LOAD = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD    = 8'(GAP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       is_read_q, is_read_d;
  logic       wait_n_q, wait_n_d;
  logic       csr_n_q, csr_n_d;
  logic       csw_n_q, csw_n_d;
  logic       mode_q, mode_d;
  logic [7:0] cd_o_q, cd_o_d;
  logic [7:0] d_o_q, d_o_d;
  logic       access_valid;

  // Exactly one of rd_n/wr_n low; both-low or both-high is not an access.
  assign access_valid = !iorq_n && (addr[7:2] == BASE_PORT[7:2]) && (rd_n ^ wr_n);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_read_d = is_read_q;
    wait_n_d  = wait_n_q;
    csr_n_d   = csr_n_q;
    csw_n_d   = csw_n_q;
    mode_d    = mode_q;
    cd_o_d    = cd_o_q;
    d_o_d     = d_o_q;
    case (state_q)
      IDLE: begin
        if (access_valid) begin
          state_d   = SETUP;
          wait_n_d  = 1'b0;
          mode_d    = addr[1];
          is_read_d = !rd_n;
          if (rd_n) begin
            cd_o_d = cpu_d_i;
          end
        end
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = STROBE_LOAD;
        if (is_read_q) begin
          csr_n_d = 1'b0;
        end else begin
          csw_n_d = 1'b0;
        end
      end
      STROBE: begin
        if (cnt_q == 8'd0) begin
          state_d  = HOLD;
          csr_n_d  = 1'b1;
          csw_n_d  = 1'b1;
          wait_n_d = 1'b1;
          if (is_read_q) begin
            d_o_d = vdp_cd_i;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HOLD: begin
        if (iorq_n) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end
      end
      GAP: begin
        // Recovery time for the VDP; new requests simply wait for IDLE.
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      is_read_q <= 1'b0;
      wait_n_q  <= 1'b1;
      csr_n_q   <= 1'b1;
      csw_n_q   <= 1'b1;
      mode_q    <= 1'b0;
      cd_o_q    <= 8'd0;
      d_o_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_read_q <= is_read_d;
      wait_n_q  <= wait_n_d;
      csr_n_q   <= csr_n_d;
      csw_n_q   <= csw_n_d;
      mode_q    <= mode_d;
      cd_o_q    <= cd_o_d;
      d_o_q     <= d_o_d;
    end
  end

  // Bus drive follows the live CPU read so we release as soon as rd_n rises.
  assign cpu_d_oe  = !RESET && (state_q == HOLD) && is_read_q && !iorq_n && !rd_n;
  assign cpu_d_o   = d_o_q;
  assign wait_n    = wait_n_q;
  assign vdp_csr_n = csr_n_q;
  assign vdp_csw_n = csw_n_q;
  assign vdp_mode  = mode_q;
  assign vdp_cd_o  = cd_o_q;

endmodule

// File: tb/tb_vdp_bus_bridge.sv
// Self-checking bench for vdp_bus_bridge: timeline-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_vdp_bus_bridge;

  localparam int N = 8;
  localparam int G = 4;
  localparam logic [7:0] BASE = 8'h30;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       iorq_n = 1'b1;
  logic       rd_n = 1'b1;
  logic       wr_n = 1'b1;
  logic [7:0] addr = 8'h00;
  logic [7:0] cpu_d_i = 8'h00;
  logic [7:0] vdp_cd_i = 8'h00;
  logic [7:0] cpu_d_o;
  logic       cpu_d_oe;
  logic       wait_n;
  logic       vdp_csr_n;
  logic       vdp_csw_n;
  logic       vdp_mode;
  logic [7:0] vdp_cd_o;

  int checks = 0;
  int errors = 0;

  vdp_bus_bridge #(
    .BASE_PORT(BASE),
    .STROBE_CYCLES(N),
    .GAP_CYCLES(G)
  ) dut (
    .clk(clk),
    .RESET(RESET),
    .iorq_n(iorq_n),
    .rd_n(rd_n),
    .wr_n(wr_n),
    .addr(addr),
    .cpu_d_i(cpu_d_i),
    .cpu_d_o(cpu_d_o),
    .cpu_d_oe(cpu_d_oe),
    .wait_n(wait_n),
    .vdp_csr_n(vdp_csr_n),
    .vdp_csw_n(vdp_csw_n),
    .vdp_mode(vdp_mode),
    .vdp_cd_o(vdp_cd_o),
    .vdp_cd_i(vdp_cd_i)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic iorq, input logic rd, input logic wr,
                               input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    iorq_n  = iorq;
    rd_n    = rd;
    wr_n    = wr;
    addr    = a;
    cpu_d_i = d;
  endtask

  // Reference model: an accepted access is described by the edge on which it
  // was accepted and the edge on which the CPU ended it; every output is a
  // plain function of the distance from those two edges.
  int         cyc = 0;
  bit         mdlValid = 1'b0;
  bit         busy = 1'b0;
  bit         isRd = 1'b0;
  int         accEdge = 0;
  int         holdEnd = -1;
  int         rel;
  logic [7:0] mMode = 8'h00;
  logic [7:0] mWdata = 8'h00;
  logic [7:0] mRdata = 8'h00;
  bit         strobeLow;
  bit         expOe;

  always begin
    @(posedge clk);
    cyc++;
    if (RESET) begin
      mdlValid = 1'b1;
      busy     = 1'b0;
      holdEnd  = -1;
      mMode    = 8'h00;
      mWdata   = 8'h00;
      mRdata   = 8'h00;
    end else if (!busy) begin
      if (!iorq_n && addr[7:2] == BASE[7:2] && rd_n != wr_n) begin
        busy    = 1'b1;
        accEdge = cyc;
        holdEnd = -1;
        isRd    = !rd_n;
        mMode   = {7'd0, addr[1]};
        if (!isRd) mWdata = cpu_d_i;
      end
    end else begin
      if (isRd && cyc == accEdge + N + 1) mRdata = vdp_cd_i;
      if (holdEnd < 0 && cyc >= accEdge + N + 2 && iorq_n) holdEnd = cyc;
      else if (holdEnd >= 0 && cyc == holdEnd + G) busy = 1'b0;
    end
    #1;
    if (mdlValid) begin
      rel       = cyc - accEdge;
      strobeLow = busy && rel >= 1 && rel <= N;
      expOe     = busy && holdEnd < 0 && rel >= N + 1 && isRd && !iorq_n && !rd_n && !RESET;
      checkOutput("wait_n", wait_n, !(busy && rel >= 0 && rel <= N));
      checkOutput("vdp_csr_n", vdp_csr_n, !(strobeLow && isRd));
      checkOutput("vdp_csw_n", vdp_csw_n, !(strobeLow && !isRd));
      checkOutput("vdp_mode", vdp_mode, mMode);
      checkOutput("vdp_cd_o", vdp_cd_o, mWdata);
      checkOutput("cpu_d_o", cpu_d_o, mRdata);
      checkOutput("cpu_d_oe", cpu_d_oe, expOe);
    end
  end

  task automatic doAccess(input logic isRead, input logic [7:0] a, input logic [7:0] d,
                          input int holdExtra, output int waitLow, output int strobeLow_o,
                          output int otherLow, output int oeHigh, output int fallEdge);
    bit done;
    applyStimulus(1'b0, !isRead, isRead, a, d);
    waitLow = 0; strobeLow_o = 0; otherLow = 0; oeHigh = 0; fallEdge = -1; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1;
      if (!wait_n) waitLow++;
      else if (waitLow > 0) done = 1'b1;
      if (!(isRead ? vdp_csr_n : vdp_csw_n)) begin
        strobeLow_o++;
        if (fallEdge < 0) fallEdge = cyc;
      end
      if (!(isRead ? vdp_csw_n : vdp_csr_n)) otherLow++;
      if (cpu_d_oe) oeHigh++;
    end
    checkOutput("access_done", done, 1);
    repeat (holdExtra) begin
      @(posedge clk); #1;
      if (cpu_d_oe) oeHigh++;
    end
    applyStimulus(1'b1, 1'b1, 1'b1, a, d);
  endtask

  task automatic holdPattern(input logic r, input logic w, input logic [7:0] a, input int n,
                             output int waitLow, output int strobes);
    applyStimulus(1'b0, r, w, a, 8'hFF);
    waitLow = 0; strobes = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (!wait_n) waitLow++;
      if (!vdp_csr_n || !vdp_csw_n) strobes++;
    end
    applyStimulus(1'b1, 1'b1, 1'b1, a, 8'h00);
  endtask

  initial begin
    int wl, sl, ol, oe, fe, fe2, hEdge, cnt, len, rw, idle;
    logic r, w;
    logic [7:0] a;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_wait_n", wait_n, 1);
    checkOutput("rst_csr_n", vdp_csr_n, 1);
    checkOutput("rst_csw_n", vdp_csw_n, 1);
    checkOutput("rst_mode", vdp_mode, 0);
    checkOutput("rst_cd_o", vdp_cd_o, 8'h00);
    checkOutput("rst_d_o", cpu_d_o, 8'h00);
    checkOutput("rst_oe", cpu_d_oe, 0);
    @(negedge clk); RESET = 1'b0;
    repeat (2) @(negedge clk);

    // Write 0x5A to port 0x30
    doAccess(1'b0, 8'h30, 8'h5A, 1, wl, sl, ol, oe, fe);
    checkOutput("wr_wait_low", wl, 9);
    checkOutput("wr_csw_low", sl, 8);
    checkOutput("wr_csr_low", ol, 0);
    checkOutput("wr_mode", vdp_mode, 0);
    checkOutput("wr_cd_o", vdp_cd_o, 8'h5A);
    repeat (8) @(negedge clk);

    // Read port 0x32 returning 0xC3
    vdp_cd_i = 8'hC3;
    doAccess(1'b1, 8'h32, 8'h00, 3, wl, sl, ol, oe, fe);
    #1;
    checkOutput("rd_oe_release", cpu_d_oe, 0);
    checkOutput("rd_wait_low", wl, 9);
    checkOutput("rd_csr_low", sl, 8);
    checkOutput("rd_csw_low", ol, 0);
    checkOutput("rd_oe_cycles", oe, 4);
    checkOutput("rd_mode", vdp_mode, 1);
    checkOutput("rd_d_o", cpu_d_o, 8'hC3);
    repeat (8) @(negedge clk);

    // Back-to-back writes: gap of G clks then one SETUP clk
    doAccess(1'b0, 8'h30, 8'h11, 0, wl, sl, ol, oe, fe);
    hEdge = cyc + 1;
    doAccess(1'b0, 8'h31, 8'h22, 0, wl, sl, ol, oe, fe2);
    checkOutput("b2b_fall_delay", fe2 - hEdge, G + 2);
    checkOutput("b2b_csw_low", sl, 8);
    checkOutput("b2b_cd_o", vdp_cd_o, 8'h22);
    repeat (8) @(negedge clk);

    // Ignored patterns: non-matching port, both strobes requested
    holdPattern(1'b1, 1'b0, 8'h40, 12, wl, sl);
    checkOutput("nomatch_wait", wl, 0);
    checkOutput("nomatch_strobe", sl, 0);
    holdPattern(1'b0, 1'b0, 8'h30, 12, wl, sl);
    checkOutput("bothlow_wait", wl, 0);
    checkOutput("bothlow_strobe", sl, 0);
    repeat (2) @(negedge clk);

    // Reset on the 4th strobe clock, then a normal access
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h30, 8'hA5);
    cnt = 0;
    for (int i = 0; i < 40 && cnt < 4; i++) begin
      @(posedge clk); #1;
      if (!vdp_csw_n) cnt++;
    end
    checkOutput("midrst_reached", cnt, 4);
    @(negedge clk); RESET = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_csw_n", vdp_csw_n, 1);
    checkOutput("midrst_wait_n", wait_n, 1);
    checkOutput("midrst_cd_o", vdp_cd_o, 8'h00);
    @(negedge clk);
    RESET = 1'b0; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    doAccess(1'b0, 8'h33, 8'h3C, 0, wl, sl, ol, oe, fe);
    checkOutput("postrst_wait_low", wl, 9);
    checkOutput("postrst_csw_low", sl, 8);
    checkOutput("postrst_mode", vdp_mode, 1);
    checkOutput("postrst_cd_o", vdp_cd_o, 8'h3C);

    // Randomized traffic with occasional resets, checked by the model
    for (int t = 0; t < 150; t++) begin
      len  = $urandom_range(1, 20);
      idle = $urandom_range(0, 6);
      rw   = $urandom_range(0, 7);
      a    = ($urandom_range(0, 4) == 0) ? 8'($urandom) : (BASE | 8'($urandom_range(0, 3)));
      r    = !(rw <= 2 || rw == 6);
      w    = !((rw >= 3 && rw <= 5) || rw == 6);
      applyStimulus(1'b0, r, w, a, 8'($urandom));
      repeat (len) begin
        @(negedge clk);
        vdp_cd_i = 8'($urandom);
        RESET = ($urandom_range(0, 60) == 0);
      end
      @(negedge clk); RESET = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b1, a, cpu_d_i);
      repeat (idle) begin
        @(negedge clk);
        vdp_cd_i = 8'($urandom);
      end
    end
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
